// File: rtl/synch_pkg.sv
// Shared constants and helpers for the synchroniser / edge-detect bank.
// Holds the minimum synchroniser depth, the default debounce length and
// the debounce counter width function used by each channel.
package synch_pkg;

  localparam int STAGES_MIN    = 2;
  localparam int DB_CYCLES_DEF = 16;

  // Width needed to hold values 0..db inclusive.
  function automatic int cnt_width(input int db);
    return $clog2(db + 1);
  endfunction

endpackage

// File: rtl/synch_edge_chan.sv
// One channel: STAGES-deep synchroniser, optional debounce, level register
// and registered rise/fall pulses.
// Latency: STAGES+DB_CYCLES edges with debounce, STAGES+1 edges without.
// Backpressure: none; en_i=0 freezes the level and suppresses pulses only.
// Ports: clk, rst (async active-high), in_i (async raw), en_i,
//        level_o, rise_o, fall_o.
// Optional feature: `define SYNCH_EDGE_DEBOUNCE_EN to compile in debounce.
module synch_edge_chan
  import synch_pkg::*;
#(
  parameter int       STAGES    = STAGES_MIN,
  parameter int       DB_CYCLES = DB_CYCLES_DEF,
  parameter logic     RST_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  input  logic en_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              sync;
  logic              level_q, level_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  // Synchroniser keeps sampling regardless of en_i.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_LEVEL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], in_i};
    end
  end

  assign sync = sync_q[STAGES-1];

`ifdef SYNCH_EDGE_DEBOUNCE_EN
  localparam int            CW       = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive enabled cycles of mismatch; any match or disable
  // restarts the count, so a re-enable always needs a full DB_CYCLES.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (en_i && (sync != level_q)) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync;
        rise_d  = sync;
        fall_d  = ~sync;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (en_i) begin
      level_d = sync;
      rise_d  = sync & ~level_q;
      fall_d  = ~sync & level_q;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= RST_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/synch_edge_bank.sv
// Bank of CH independent synchronise / debounce / edge-detect channels.
// Latency: STAGES+DB_CYCLES edges (debounce) or STAGES+1 edges (no debounce).
// Backpressure: none; per-channel en gates level updates and pulses.
// Ports: clk, rst (async active-high), in[CH] (async), en[CH],
//        level[CH], rise[CH], fall[CH].
// Optional feature: `define SYNCH_EDGE_DEBOUNCE_EN to compile in debounce.
module synch_edge_bank
  import synch_pkg::*;
#(
  parameter int   CH        = 4,
  parameter int   STAGES    = STAGES_MIN,
  parameter int   DB_CYCLES = DB_CYCLES_DEF,
  parameter logic RST_LEVEL = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] in,
  input  logic [CH-1:0] en,
  output logic [CH-1:0] level,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall
);

  for (genvar i = 0; i < CH; i++) begin : g_chan
    synch_edge_chan #(
      .STAGES    (STAGES),
      .DB_CYCLES (DB_CYCLES),
      .RST_LEVEL (RST_LEVEL)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .in_i    (in[i]),
      .en_i    (en[i]),
      .level_o (level[i]),
      .rise_o  (rise[i]),
      .fall_o  (fall[i])
    );
  end

endmodule

// File: tb/tb_synch_edge_bank.sv
module tb_synch_edge_bank;

  localparam int CH        = 4;
  localparam int STAGES    = 2;
  localparam int DB_CYCLES = 4;
`ifdef SYNCH_EDGE_DEBOUNCE_EN
  localparam int DBE = DB_CYCLES;
`else
  localparam int DBE = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] in;
  logic [CH-1:0] en;
  logic [CH-1:0] level, rise, fall;

  int checks = 0;
  int errors = 0;

  synch_edge_bank #(
    .CH        (CH),
    .STAGES    (STAGES),
    .DB_CYCLES (DB_CYCLES),
    .RST_LEVEL (1'b0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in),
    .en    (en),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] l;
    logic [CH-1:0] r;
    logic [CH-1:0] f;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: input samples delayed by STAGES edges give the
  // synchronised view; level follows it after DBE consecutive enabled
  // cycles of disagreement.
  bit hist [CH][STAGES];
  bit mlev [CH];
  int run  [CH];

  always @(posedge clk) begin
    exp_t e;
    e = '0;
    for (int c = 0; c < CH; c++) begin
      bit s;
      if (rst) begin
        for (int k = 0; k < STAGES; k++) hist[c][k] = 1'b0;
        mlev[c] = 1'b0;
        run[c]  = 0;
      end else begin
        s = hist[c][STAGES-1];
        if (!en[c] || s == mlev[c]) begin
          run[c] = 0;
        end else begin
          run[c] = run[c] + 1;
          if (run[c] >= DBE) begin
            mlev[c] = s;
            run[c]  = 0;
            if (s) e.r[c] = 1'b1;
            else   e.f[c] = 1'b1;
          end
        end
        for (int k = STAGES - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = in[c];
      end
      e.l[c] = mlev[c];
    end
    exp_q.push_back(e);
  end

  // Monitor: one output word per cycle, compared away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (level !== e.l || rise !== e.r || fall !== e.f || (rise & fall) != '0) begin
        errors++;
        $display("FAIL scoreboard t=%0t got level=%b rise=%b fall=%b want level=%b rise=%b fall=%b",
                 $time, level, rise, fall, e.l, e.r, e.f);
      end
    end
  end

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Counts rising edges until the selected pulse appears; -1 on timeout.
  task automatic wait_pulse(input int ch, input bit rising, input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk);
      #1;
      if (rising ? rise[ch] : fall[ch]) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic wait_all(input bit rising, input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk);
      #1;
      if ((rising ? rise : fall) == {CH{1'b1}}) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n, nr, nf;
    rst = 1'b1;
    in  = '0;
    en  = '1;
    #1;
    check_int("reset_level", int'(level), 0);
    check_int("reset_pulses", int'(rise | fall), 0);
    repeat (3) @(negedge clk);

    // Clean edge on channel 0, input settled before edge 1.
    in[0] = 1'b1;
    rst   = 1'b0;
    wait_pulse(0, 1'b1, 40, n);
    check_int("clean_edge_latency", n, STAGES + DBE);

    // Short excursion on channel 1.
    @(negedge clk);
    in[1] = 1'b1;
    repeat (2) @(negedge clk);
    in[1] = 1'b0;
    repeat (12) @(negedge clk);

    // Disable channel 2 while its input rises, then re-enable.
    en[2] = 1'b0;
    in[2] = 1'b1;
    repeat (12) @(negedge clk);
    check_int("disabled_level", int'(level[2]), 0);
    en[2] = 1'b1;
    wait_pulse(2, 1'b1, 40, n);
    check_int("reenable_latency", n, DBE);

    // Async reset in the middle of a debounce on channel 3.
    @(negedge clk);
    in[3] = 1'b1;
    repeat (STAGES + 1) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_int("async_rst_level", int'(level), 0);
    check_int("async_rst_pulses", int'(rise | fall), 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    wait_pulse(3, 1'b1, 40, n);
    check_int("post_reset_latency", n, STAGES + DBE);

    // Simultaneous edges on every channel, input low again 20 cycles later.
    @(negedge clk);
    in = '0;
    repeat (20) @(negedge clk);
    in = '1;
    wait_all(1'b1, 40, nr);
    check_int("simul_rise_latency", nr, STAGES + DBE);
    repeat (21 - nr) @(negedge clk);
    in = '0;
    wait_all(1'b0, 40, nf);
    check_int("simul_fall_spacing", nf, nr);

    // Randomised traffic with occasional enable changes.
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 5) == 0) in[c] = ~in[c];
        if ($urandom_range(0, 39) == 0) en[c] = ~en[c];
      end
    end

    // Toggle channel 0 every two cycles with debounce-free expectations
    // handled by the model either way.
    en = '1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (cyc % 2 == 0) in[0] = ~in[0];
    end

    repeat (30) @(negedge clk);
    check_int("scoreboard_drained", (exp_q.size() <= 1) ? 1 : 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
